// File: rtl/capture_pkg.sv
// Constants and FSM encoding shared by the capture-value UART sender and receiver.
package capture_pkg;

    localparam int          NUM_DIGITS = 7;
    localparam logic [7:0]  SOF_CHAR   = 8'h43;
    localparam logic [7:0]  ASCII_ZERO = 8'h30;
    localparam logic [7:0]  ASCII_NINE = 8'h39;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1
    } state_t;

endpackage

// File: rtl/bcd_weight_acc.sv
// Decimal-weighted accumulator: acc += digit*weight, then weight *= 10, using shifts and adds only.
module bcd_weight_acc
    import capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        step,
    input  logic [3:0]  digit,
    output logic [31:0] acc
);

    logic [31:0] weight;
    logic [31:0] product;

    // 4x32 shift-add multiply of the digit by the current weight.
    always_comb begin
        product = ({32{digit[0]}} & weight)
                + ({32{digit[1]}} & (weight << 1))
                + ({32{digit[2]}} & (weight << 2))
                + ({32{digit[3]}} & (weight << 3));
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            weight <= 32'd1;
        end else if (clear) begin
            acc    <= '0;
            weight <= 32'd1;
        end else if (step) begin
            acc    <= acc + product;
            weight <= (weight << 3) + (weight << 1);
        end
    end

endmodule

// File: rtl/capture_rx_parser.sv
// Recognises 'C' + NUM_DIGITS ASCII digits (LSD first) and emits the decoded binary value.
module capture_rx_parser #(
    parameter int         NUM_DIGITS     = capture_pkg::NUM_DIGITS,
    parameter logic [7:0] SOF_CHAR       = capture_pkg::SOF_CHAR,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TO_W           = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [7:0]  err_count
);

    import capture_pkg::state_t, capture_pkg::IDLE, capture_pkg::DIGITS;
    import capture_pkg::ASCII_ZERO, capture_pkg::ASCII_NINE;

    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      IDX_LAST = 4'(NUM_DIGITS - 1);

    state_t          state;
    logic [3:0]      idx;
    logic [TO_W-1:0] to_cnt;
    logic            done_pend;
    logic [31:0]     acc;

    logic            is_sof;
    logic            is_digit;
    logic [3:0]      digit;
    logic            acc_clear;
    logic            acc_step;
    logic            abort;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        is_sof    = (rx_data == SOF_CHAR);
        is_digit  = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
        digit     = 4'(rx_data - ASCII_ZERO);
        acc_clear = rx_valid && is_sof;
        acc_step  = (state == DIGITS) && rx_valid && is_digit;
        // A byte arriving in the expiry cycle pre-empts the timeout.
        abort     = (state == DIGITS) && (rx_valid ? !is_digit : (to_cnt == TO_LAST));
    end

    bcd_weight_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear),
        .step  (acc_step),
        .digit (digit),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            to_cnt      <= '0;
            done_pend   <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            done_pend   <= 1'b0;

            // The accumulator settles on the accepting edge; publish it one edge later.
            if (done_pend) begin
                value       <= acc;
                value_valid <= 1'b1;
            end

            if (abort) begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (rx_valid && is_sof) begin
                        state  <= DIGITS;
                        idx    <= '0;
                        to_cnt <= '0;
                    end
                end
                DIGITS: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        if (is_digit) begin
                            if (idx == IDX_LAST) begin
                                state     <= IDLE;
                                done_pend <= 1'b1;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end else if (is_sof) begin
                            idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (abort) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == DIGITS);

endmodule
